// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings, opcode/funct
// constants, ALU operation codes and datapath select codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_BR = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_RTYPE   = 4'd0,
        CLS_ADDI    = 4'd1,
        CLS_ORI     = 4'd2,
        CLS_LW      = 4'd3,
        CLS_SW      = 4'd4,
        CLS_BEQ     = 4'd5,
        CLS_J       = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_HALT    = 4'd9,
        CLS_ILLEGAL = 4'd10
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PC_SEL_PC4    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
    localparam logic [1:0] PC_SEL_RS     = 2'd3;

    localparam logic [1:0] ALUB_SEL_RT   = 2'd0;
    localparam logic [1:0] ALUB_SEL_SEXT = 2'd1;
    localparam logic [1:0] ALUB_SEL_ZEXT = 2'd2;
    localparam logic [1:0] ALUB_SEL_ZERO = 2'd3;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [1:0] REGDST_SEL_RT   = 2'd0;
    localparam logic [1:0] REGDST_SEL_RD   = 2'd1;
    localparam logic [1:0] REGDST_SEL_R31  = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode: opcode/funct to instruction class and ALU op.
// Undefined opcodes and unknown R-type funct values decode as CLS_ILLEGAL.
module ctrl_decode
    import multicycle_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    output instr_class_t      cls,
    output logic [ALUOPW-1:0] aluOp
);

    // Map the instruction fields onto a class and the ALU operation it needs
    always_comb begin
        cls   = CLS_ILLEGAL;
        aluOp = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin cls = CLS_RTYPE; aluOp = ALU_ADD; end
                    FN_SUB:  begin cls = CLS_RTYPE; aluOp = ALU_SUB; end
                    FN_AND:  begin cls = CLS_RTYPE; aluOp = ALU_AND; end
                    FN_OR:   begin cls = CLS_RTYPE; aluOp = ALU_OR;  end
                    FN_SLT:  begin cls = CLS_RTYPE; aluOp = ALU_SLT; end
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: begin cls = CLS_ADDI; aluOp = ALU_ADD; end
            OP_ORI:  begin cls = CLS_ORI;  aluOp = ALU_OR;  end
            OP_LW:   begin cls = CLS_LW;   aluOp = ALU_ADD; end
            OP_SW:   begin cls = CLS_SW;   aluOp = ALU_ADD; end
            OP_BEQ:  begin cls = CLS_BEQ;  aluOp = ALU_SUB; end
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (IF/ID/EXE/MEM/WB) with registered Moore outputs.
// Optional MEM_WAIT_EN: MEM stretches until mem_ready is sampled high.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_wre,
    output logic              ir_wre,
    output logic              reg_wre,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        pc_sel,
    output logic [1:0]        alub_sel,
    output logic [1:0]        wb_sel,
    output logic [1:0]        regdst_sel,
    output logic [3:0]        state,
    output logic              halted,
    output logic              illegal
);

    state_t              stateR;
    instr_class_t        decCls;
    instr_class_t        clsR;
    logic [ALUOPW-1:0]   decAluOp;
    logic [ALUOPW-1:0]   aluOpR;
    logic                memDoneR;
    logic                readyNow;
    logic                isLw;
    logic                isSw;

    ctrl_decode #(.OPW(OPW), .ALUOPW(ALUOPW)) uDecode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (decCls),
        .aluOp  (decAluOp)
    );

`ifdef MEM_WAIT_EN
    assign readyNow = mem_ready;
`else
    logic unusedMemReady;
    assign unusedMemReady = mem_ready;
    assign readyNow       = 1'b1;
`endif

    assign isLw  = (clsR == CLS_LW);
    assign isSw  = (clsR == CLS_SW);
    assign state = stateR;

    // State and output registers: outputs are loaded with the values of the state being entered.
    // Decode is captured on entry to ID; zero and mem_ready are sampled on entry to their state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR     <= S_IF;
            clsR       <= CLS_ILLEGAL;
            aluOpR     <= '0;
            memDoneR   <= 1'b0;
            pc_wre     <= 1'b0;
            ir_wre     <= 1'b0;
            reg_wre    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            alu_op     <= '0;
            pc_sel     <= PC_SEL_PC4;
            alub_sel   <= ALUB_SEL_RT;
            wb_sel     <= WB_SEL_ALU;
            regdst_sel <= REGDST_SEL_RT;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            pc_wre     <= 1'b0;
            ir_wre     <= 1'b0;
            reg_wre    <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            alu_op     <= '0;
            pc_sel     <= PC_SEL_PC4;
            alub_sel   <= ALUB_SEL_RT;
            wb_sel     <= WB_SEL_ALU;
            regdst_sel <= REGDST_SEL_RT;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            case (stateR)
                S_IF: begin
                    stateR <= S_ID;
                    clsR   <= decCls;
                    aluOpR <= decAluOp;
                    case (decCls)
                        CLS_J: begin
                            pc_wre <= 1'b1;
                            pc_sel <= PC_SEL_JUMP;
                        end
                        CLS_JAL: begin
                            pc_wre     <= 1'b1;
                            pc_sel     <= PC_SEL_JUMP;
                            reg_wre    <= 1'b1;
                            wb_sel     <= WB_SEL_PC4;
                            regdst_sel <= REGDST_SEL_R31;
                        end
                        CLS_JR: begin
                            pc_wre <= 1'b1;
                            pc_sel <= PC_SEL_RS;
                        end
                        CLS_ILLEGAL: begin
                            pc_wre  <= 1'b1;
                            illegal <= 1'b1;
                        end
                        default: begin
                            pc_wre <= 1'b0;
                        end
                    endcase
                end
                S_ID: begin
                    case (clsR)
                        CLS_HALT: begin
                            stateR <= S_HALT;
                            halted <= 1'b1;
                        end
                        CLS_BEQ: begin
                            stateR <= S_EXE_BR;
                            alu_op <= ALU_SUB;
                            pc_wre <= 1'b1;
                            pc_sel <= zero ? PC_SEL_BRANCH : PC_SEL_PC4;
                        end
                        CLS_LW, CLS_SW: begin
                            stateR   <= S_EXE_LS;
                            alu_op   <= ALU_ADD;
                            alub_sel <= ALUB_SEL_SEXT;
                        end
                        CLS_RTYPE, CLS_ADDI, CLS_ORI: begin
                            stateR   <= S_EXE_AL;
                            alu_op   <= aluOpR;
                            alub_sel <= (clsR == CLS_ADDI) ? ALUB_SEL_SEXT :
                                        (clsR == CLS_ORI)  ? ALUB_SEL_ZEXT : ALUB_SEL_RT;
                        end
                        default: begin
                            stateR <= S_IF;
                            ir_wre <= 1'b1;
                        end
                    endcase
                end
                S_EXE_AL: begin
                    stateR     <= S_WB_AL;
                    reg_wre    <= 1'b1;
                    pc_wre     <= 1'b1;
                    regdst_sel <= (clsR == CLS_RTYPE) ? REGDST_SEL_RD : REGDST_SEL_RT;
                end
                S_EXE_LS: begin
                    stateR   <= S_MEM;
                    mem_rd   <= isLw;
                    mem_wr   <= isSw;
                    memDoneR <= readyNow;
                    pc_wre   <= isSw && readyNow;
                end
                S_MEM: begin
                    if (!memDoneR) begin
                        stateR   <= S_MEM;
                        mem_rd   <= isLw;
                        mem_wr   <= isSw;
                        memDoneR <= readyNow;
                        pc_wre   <= isSw && readyNow;
                    end else if (isLw) begin
                        stateR  <= S_WB_LD;
                        reg_wre <= 1'b1;
                        wb_sel  <= WB_SEL_MEM;
                        pc_wre  <= 1'b1;
                    end else begin
                        stateR <= S_IF;
                        ir_wre <= 1'b1;
                    end
                end
                S_EXE_BR, S_WB_AL, S_WB_LD: begin
                    stateR <= S_IF;
                    ir_wre <= 1'b1;
                end
                S_HALT: begin
                    stateR <= S_HALT;
                    halted <= 1'b1;
                end
                default: begin
                    stateR <= S_IF;
                    ir_wre <= 1'b1;
                end
            endcase
        end
    end

endmodule
